fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Fetch/execute controller sitting directly upstream of the ALU. It owns the program counter, instruction register and carry flag. It fetches 16-bit instruction words over a req/ack memory handshake and presents each word to the ALU as `instr` with a one-cycle `exec1` strobe. It resolves control-flow opcodes itself and captures the ALU carry on `carryen`.

## Interface
- `ADDR_W`, 8, program counter / memory address width (8..16).
- `RESET_PC`, 0, program counter value after reset.
- `clk`  in  1  system clock, all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  leave IDLE/HALT and begin fetching; level-sampled.
- `mem_req`  out  1  instruction fetch request, held until acknowledged.
- `mem_addr`  out  ADDR_W  fetch address; equals `pc` whenever `mem_req`=1.
- `mem_ack`  in  1  fetch data valid this cycle; ignored when `mem_req`=0.
- `mem_rdata`  in  16  instruction word, sampled on `mem_req & mem_ack`.
- `instr`  out  16  instruction register, drives the ALU `instr` input.
- `exec1`  out  1  one-cycle execute strobe, drives the ALU `exec1` input.
- `carrystatus`  out  1  carry flag register, drives the ALU `carrystatus` input.
- `carryout`  in  1  ALU carry result.
- `carryen`  in  1  ALU carry-update enable (already qualified by `exec1`).
- `pc`  out  ADDR_W  current program counter.
- `halted`  out  1  high while in HALT.

## Operation
- States: IDLE, FETCH, EXEC, HALT.
- IDLE:
  - `start`=1 goes to FETCH.
  - Otherwise stays in IDLE.
- FETCH:
  - `mem_req`=1, `mem_addr`=`pc`.
  - On `mem_ack`=1: `instr`<=`mem_rdata`, go to EXEC.
  - Otherwise stays in FETCH with address stable.
- EXEC: `exec1`=1 for exactly this cycle. `instr` is stable.
- Opcode is `instr[15:8]`. Target is `instr[7:0]`, zero-extended to ADDR_W.
- Carry used by the branch opcodes is the `carrystatus` value before the EXEC edge.
- EXEC resolution by opcode:
  - 8'h01 JMP: `pc`<=target, go to FETCH.
  - 8'h02 JC: if `carrystatus`=1, `pc`<=target; else `pc`<=`pc`+1. Go to FETCH.
  - 8'h03 JNC: if `carrystatus`=0, `pc`<=target; else `pc`<=`pc`+1. Go to FETCH.
  - 8'h0F HALT: `pc`<=`pc`+1, go to HALT.
  - All other opcodes (ALU ops 8'hF8–8'hFE, I/O, NOP): `pc`<=`pc`+1, go to FETCH.
- Carry update: in EXEC, if `carryen`=1 then `carrystatus`<=`carryout`. Outside EXEC the flag holds.
- HALT: `halted`=1.
  - `start`=1 resumes at FETCH from the current `pc`, the address after HALT.
- `start` is ignored in FETCH and EXEC.
- `pc` arithmetic is modulo 2^ADDR_W: all-ones +1 wraps to 0.

## Timing
- Reset values (asynchronous):
  - State: IDLE.
  - `pc`=RESET_PC.
  - `instr`=16'h0000.
  - `carrystatus`=0.
  - `mem_req`=0, `exec1`=0, `halted`=0.
  - `mem_addr`=RESET_PC.
- `mem_req`, `exec1` and `halted` are decoded from registered state only. No combinational path from any input to any output.
- Ack is accepted in the same cycle `mem_req` rises. A zero-wait instruction therefore takes 2 cycles: FETCH, EXEC. N wait cycles add N.
- `exec1` is never asserted on two consecutive cycles.
- `instr` changes only at the edge leaving FETCH.
- Reset asserted mid-FETCH drops `mem_req` immediately. A late `mem_ack` after reset is ignored.
- Reset during EXEC discards the carry update and the PC update.

## Test plan
- Reset, then `start`=1 with mem returning 16'hF800 at addr 0, ack immediate:
  - `mem_req` at cycle 1, `exec1` at cycle 2 with `instr`=16'hF800.
  - `pc`=1 at cycle 3.
- Ack delayed 3 cycles:
  - `mem_req` and `mem_addr` held stable for 4 cycles.
  - Exactly one `exec1` pulse.
  - `instr` unchanged until the ack edge.
- Program: addr0 16'hF801 with `carryen`=1, `carryout`=1; addr1 16'h0205 (JC 5):
  - `carrystatus`=1 after the first EXEC.
  - Next fetch address is 5.
  - Same program with `carryout`=0: next fetch address is 2.
- JMP 16'h01FF at `pc`=0, then a plain op at 0xFF:
  - Fetch at 0xFF.
  - Following fetch at 0x00 (wrap).
- HALT 16'h0F00 at addr 3:
  - `halted`=1 with `pc`=4 and no `mem_req`.
  - `start`=1 resumes with fetch at 4.
- Reset pulsed in the middle of a wait-stated FETCH:
  - Outputs at reset values immediately.
  - Ack arriving afterwards produces no `exec1`.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Fetch/execute controller feeding the ALU. Owns the program counter, the
// instruction register and the carry flag. Fetches 16-bit words over a
// req/ack handshake, presents each one to the ALU with a one-cycle exec1
// strobe, resolves jumps/branches/halt locally and captures the ALU carry.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             leave IDLE/HALT and begin fetching (level)
//   mem_req/mem_addr  fetch request and address (address = pc)
//   mem_ack/mem_rdata fetch acknowledge and instruction word
//   instr, exec1      instruction register and execute strobe to the ALU
//   carrystatus       carry flag to the ALU
//   carryout/carryen  carry result and update enable from the ALU
//   pc, halted        program counter and HALT indication
module fetch_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       instr,
    output logic              exec1,
    output logic              carrystatus,
    input  logic              carryout,
    input  logic              carryen,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [7:0] OP_JMP  = 8'h01;
    localparam logic [7:0] OP_JC   = 8'h02;
    localparam logic [7:0] OP_JNC  = 8'h03;
    localparam logic [7:0] OP_HALT = 8'h0F;

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_s;
    logic [15:0]       instr_r;
    logic [15:0]       instr_s;
    logic              carry_r;
    logic              carry_s;
    logic [ADDR_W-1:0] target_s;
    logic [ADDR_W-1:0] pc_inc_s;

    assign target_s = ADDR_W'(instr_r[7:0]);
    // Natural overflow of the adder gives the required modulo-2^ADDR_W wrap.
    assign pc_inc_s = pc_r + ADDR_W'(1'b1);

    // State register and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            pc_r    <= RESET_PC;
            instr_r <= 16'h0000;
            carry_r <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            instr_r <= instr_s;
            carry_r <= carry_s;
        end
    end

    // Next-state, next-pc, instruction capture and carry update.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        instr_s = instr_r;
        carry_s = carry_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    instr_s = mem_rdata;
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_EXEC: begin
                // Branch decisions use carry_r, i.e. the flag before this edge,
                // even if the ALU updates it in the same cycle.
                if (carryen) begin
                    carry_s = carryout;
                end else begin
                    carry_s = carry_r;
                end
                state_s = ST_FETCH;
                case (instr_r[15:8])
                    OP_JMP: pc_s = target_s;
                    OP_JC: begin
                        if (carry_r) begin
                            pc_s = target_s;
                        end else begin
                            pc_s = pc_inc_s;
                        end
                    end
                    OP_JNC: begin
                        if (!carry_r) begin
                            pc_s = target_s;
                        end else begin
                            pc_s = pc_inc_s;
                        end
                    end
                    OP_HALT: begin
                        pc_s    = pc_inc_s;
                        state_s = ST_HALT;
                    end
                    default: pc_s = pc_inc_s;
                endcase
            end
            ST_HALT: begin
                if (start) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_HALT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Strobes are pure decodes of the state register: no input reaches an output.
    assign mem_req     = (state_r == ST_FETCH);
    assign exec1       = (state_r == ST_EXEC);
    assign halted      = (state_r == ST_HALT);
    assign mem_addr    = pc_r;
    assign pc          = pc_r;
    assign instr       = instr_r;
    assign carrystatus = carry_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic        exec1;
    logic        carrystatus;
    logic        carryout;
    logic        carryen;
    logic [7:0]  pc;
    logic        halted;

    logic [15:0] mem [0:255];
    int          passed = 0;
    int          total  = 0;

    assign mem_rdata = mem[mem_addr];

    always #5 clk = ~clk;

    fetch_sequencer #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .instr(instr), .exec1(exec1),
        .carrystatus(carrystatus), .carryout(carryout), .carryen(carryen),
        .pc(pc), .halted(halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Synchronous-looking reset pulse, then a start pulse: returns in cycle 1 (FETCH).
    task automatic reset_and_start();
        rst = 1'b1;
        start = 1'b0;
        tick();
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        rst = 1'b1; start = 1'b0; mem_ack = 1'b1; carryout = 1'b0; carryen = 1'b0;
        #2;
        // Reset values
        chk("rst_req",    {31'd0, mem_req}, 32'd0);
        chk("rst_exec",   {31'd0, exec1}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_pc",     {24'd0, pc}, 32'd0);
        chk("rst_addr",   {24'd0, mem_addr}, 32'd0);
        chk("rst_instr",  {16'd0, instr}, 32'h0000);
        chk("rst_carry",  {31'd0, carrystatus}, 32'd0);

        // Basic zero-wait instruction
        mem[0] = 16'hF800;
        mem[1] = 16'hF900;
        tick();
        rst = 1'b0; start = 1'b1;
        tick();                       // cycle 1
        start = 1'b0;
        chk("c1_req",   {31'd0, mem_req}, 32'd1);
        chk("c1_addr",  {24'd0, mem_addr}, 32'd0);
        chk("c1_exec",  {31'd0, exec1}, 32'd0);
        tick();                       // cycle 2
        chk("c2_exec",  {31'd0, exec1}, 32'd1);
        chk("c2_instr", {16'd0, instr}, 32'hF800);
        chk("c2_req",   {31'd0, mem_req}, 32'd0);
        mem_ack = 1'b0;
        tick();                       // cycle 3
        chk("c3_pc",    {24'd0, pc}, 32'd1);
        chk("c3_exec",  {31'd0, exec1}, 32'd0);

        // Three wait states: request held four cycles, ack on the last
        for (int i = 0; i < 4; i++) begin
            chk("wait_req",   {31'd0, mem_req}, 32'd1);
            chk("wait_addr",  {24'd0, mem_addr}, 32'd1);
            chk("wait_exec",  {31'd0, exec1}, 32'd0);
            chk("wait_instr", {16'd0, instr}, 32'hF800);
            if (i == 3) mem_ack = 1'b1;
            tick();
        end
        chk("wait_exec1",  {31'd0, exec1}, 32'd1);
        chk("wait_instr1", {16'd0, instr}, 32'hF900);
        tick();
        chk("wait_noexec", {31'd0, exec1}, 32'd0);
        chk("wait_pc2",    {24'd0, mem_addr}, 32'd2);

        // Carry capture then JC / JNC with carry=1
        mem[0] = 16'hF801; mem[1] = 16'h0205; mem[2] = 16'h0307; mem[5] = 16'h0309;
        carryout = 1'b1; carryen = 1'b1;
        reset_and_start();            // c1 fetch 0
        tick();                       // c2 exec F801
        tick();                       // c3 fetch 1
        carryen = 1'b0;
        chk("jc1_carry", {31'd0, carrystatus}, 32'd1);
        chk("jc1_addr1", {24'd0, mem_addr}, 32'd1);
        tick();                       // c4 exec JC 5
        chk("jc1_instr", {16'd0, instr}, 32'h0205);
        tick();                       // c5 fetch
        chk("jc1_taken", {24'd0, mem_addr}, 32'd5);
        tick(); tick();               // exec JNC 9 with carry=1
        chk("jnc1_fall", {24'd0, mem_addr}, 32'd6);

        // Same program with carry=0
        carryout = 1'b0; carryen = 1'b1;
        reset_and_start();
        tick(); tick();
        carryen = 1'b0;
        chk("jc0_carry", {31'd0, carrystatus}, 32'd0);
        tick(); tick();
        chk("jc0_fall",  {24'd0, mem_addr}, 32'd2);
        tick(); tick();
        chk("jnc0_taken", {24'd0, mem_addr}, 32'd7);

        // JMP to 0xFF, then wrap to 0x00
        mem[0] = 16'h01FF; mem[255] = 16'hF800;
        reset_and_start();
        tick(); tick();
        chk("jmp_addr", {24'd0, mem_addr}, 32'hFF);
        chk("jmp_req",  {31'd0, mem_req}, 32'd1);
        tick(); tick();
        chk("wrap_addr", {24'd0, mem_addr}, 32'h00);
        chk("wrap_req",  {31'd0, mem_req}, 32'd1);

        // HALT at address 3, then resume at 4
        mem[0] = 16'hF800; mem[1] = 16'hF800; mem[2] = 16'hF800;
        mem[3] = 16'h0F00; mem[4] = 16'hF800;
        reset_and_start();
        for (int i = 0; i < 8; i++) tick();   // c9
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_pc",     {24'd0, pc}, 32'd4);
        chk("halt_req",    {31'd0, mem_req}, 32'd0);
        tick();
        chk("halt_stay",   {31'd0, halted}, 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("resume_req",    {31'd0, mem_req}, 32'd1);
        chk("resume_addr",   {24'd0, mem_addr}, 32'd4);
        chk("resume_halted", {31'd0, halted}, 32'd0);

        // Reset in the middle of a wait-stated fetch
        mem_ack = 1'b0;
        tick();
        chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_req",   {31'd0, mem_req}, 32'd0);
        chk("mid_rst_pc",    {24'd0, pc}, 32'd0);
        chk("mid_rst_addr",  {24'd0, mem_addr}, 32'd0);
        chk("mid_rst_instr", {16'd0, instr}, 32'h0000);
        chk("mid_rst_halt",  {31'd0, halted}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("late_ack_exec", {31'd0, exec1}, 32'd0);
            chk("late_ack_req",  {31'd0, mem_req}, 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
